// File: rtl/status_reg_stack.sv
// EXE-stage flag register with per-flag masked write-back, a save/restore stack and a
// built-in ARM condition-code check.
module status_reg_stack #(
   parameter int unsigned NFLAGS = 4,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en,
   input  logic [NFLAGS-1:0] wb_mask,
   input  logic [NFLAGS-1:0] flags_in,
   input  logic              push,
   input  logic              pop,
   input  logic              err_clr,
   input  logic [3:0]        cond,
   output logic [NFLAGS-1:0] flags_out,
   output logic              cond_pass,
   output logic [CNT_W-1:0]  depth_cnt,
   output logic              full,
   output logic              empty,
   output logic              ovf_err,
   output logic              unf_err
);

   logic [NFLAGS-1:0] stack_q [DEPTH];
   logic [NFLAGS-1:0] flags_q, flags_d, base, top_val;
   logic [CNT_W-1:0]  cnt_q, cnt_d, wr_idx;
   logic              ovf_q, ovf_d, unf_q, unf_d;
   logic              do_push, do_pop, do_xchg, stack_wr, ovf_ev, unf_ev;
   logic              f_n, f_z, f_c, f_v;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(DEPTH));

   // Push+pop on an empty stack degrades to a plain push; on a non-empty (even full) stack
   // it is an exchange of flags_out with the top entry.
   assign do_xchg = push & pop & ~empty;
   assign do_push = push & ~full & (~pop | empty);
   assign do_pop  = pop & ~push & ~empty;
   assign ovf_ev  = push & ~pop & full;
   assign unf_ev  = pop & ~push & empty;

   assign stack_wr = do_push | do_xchg;
   assign wr_idx   = do_xchg ? cnt_q - CNT_W'(1) : cnt_q;

   always_comb begin
      top_val = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (cnt_q == CNT_W'(i + 1)) top_val = stack_q[i];
      end
   end

   always_comb begin
      base    = (do_pop | do_xchg) ? top_val : flags_q;
      flags_d = base;
      if (wb_en) flags_d = (flags_in & wb_mask) | (base & ~wb_mask);
      cnt_d = cnt_q;
      if (do_push)     cnt_d = cnt_q + CNT_W'(1);
      else if (do_pop) cnt_d = cnt_q - CNT_W'(1);
      // A new error event in the same cycle as err_clr keeps the bit set.
      ovf_d = ovf_ev | (ovf_q & ~err_clr);
      unf_d = unf_ev | (unf_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         flags_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      end else begin
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (stack_wr && wr_idx == CNT_W'(i)) stack_q[i] <= flags_q;
         end
      end
   end

   assign flags_out = flags_q;
   assign depth_cnt = cnt_q;
   assign ovf_err   = ovf_q;
   assign unf_err   = unf_q;

   assign f_n = flags_q[3];
   assign f_z = flags_q[2];
   assign f_c = flags_q[1];
   assign f_v = flags_q[0];

   always_comb begin
      cond_pass = 1'b0;
      unique case (cond)
         4'h0: cond_pass = f_z;
         4'h1: cond_pass = ~f_z;
         4'h2: cond_pass = f_c;
         4'h3: cond_pass = ~f_c;
         4'h4: cond_pass = f_n;
         4'h5: cond_pass = ~f_n;
         4'h6: cond_pass = f_v;
         4'h7: cond_pass = ~f_v;
         4'h8: cond_pass = f_c & ~f_z;
         4'h9: cond_pass = ~f_c | f_z;
         4'hA: cond_pass = (f_n == f_v);
         4'hB: cond_pass = (f_n != f_v);
         4'hC: cond_pass = ~f_z & (f_n == f_v);
         4'hD: cond_pass = f_z | (f_n != f_v);
         4'hE: cond_pass = 1'b1;
         4'hF: cond_pass = 1'b0;
         default: cond_pass = 1'b0;
      endcase
   end

endmodule
